sram_req_arbiter: RTL and testbench

//  Merges the CPU's inst and data SRAM-like request ports into one SRAM-like master port that feeds
//  the AXI bridge. Arbitrates requests with a data-priority and anti-starvation policy. Records the

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_order_fifo.sv | 56 +++++
 rtl/sram_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the SRAM request arbiter: source tags, grant FSM
// encodings and the bundled request payload.
package arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_HOLD_I = 3'b010;
    localparam logic [2:0] ST_HOLD_D = 3'b100;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/arb_order_fifo.sv
// Order FIFO holding the 1-bit source tag of every accepted, unanswered request.
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     tag_i,
    output logic                     head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= tag_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges inst and data SRAM-like ports onto one master port with data priority,
// anti-starvation for inst, and in-order response routing via a tag FIFO.
module sram_req_arbiter
    import arb_pkg::*;
#(
    parameter int OUTST        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      aclk_i,
    input  logic                      areset_i,

    input  logic                      inst_req_i,
    input  logic                      inst_wr_i,
    input  logic [1:0]                inst_size_i,
    input  logic [31:0]               inst_addr_i,
    input  logic [3:0]                inst_wstrb_i,
    input  logic [31:0]               inst_wdata_i,
    output logic                      inst_addr_ok_o,
    output logic                      inst_data_ok_o,
    output logic [31:0]               inst_rdata_o,

    input  logic                      data_req_i,
    input  logic                      data_wr_i,
    input  logic [1:0]                data_size_i,
    input  logic [31:0]               data_addr_i,
    input  logic [3:0]                data_wstrb_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_addr_ok_o,
    output logic                      data_data_ok_o,
    output logic [31:0]               data_rdata_o,

    output logic                      m_req_o,
    output logic                      m_wr_o,
    output logic [1:0]                m_size_o,
    output logic [31:0]               m_addr_o,
    output logic [3:0]                m_wstrb_o,
    output logic [31:0]               m_wdata_o,
    input  logic                      m_addr_ok_i,
    input  logic                      m_data_ok_i,
    input  logic [31:0]               m_rdata_i,

    output logic [$clog2(OUTST):0]    outst_cnt_o,
    output logic                      err_orphan_o
);

    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    logic [2:0] state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       err_q, err_d;
    logic       gnt_src;
    logic       m_req_raw;
    logic       accept;
    logic       pop;
    logic       fifo_head;
    logic       fifo_empty;
    logic       fifo_full;
    req_t       inst_r, data_r, m_r;

    assign inst_r = '{wr: inst_wr_i, size: inst_size_i, addr: inst_addr_i,
                      wstrb: inst_wstrb_i, wdata: inst_wdata_i};
    assign data_r = '{wr: data_wr_i, size: data_size_i, addr: data_addr_i,
                      wstrb: data_wstrb_i, wdata: data_wdata_i};

    always_comb begin
        state_d   = state_q;
        gnt_src   = SRC_INST;
        m_req_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_req_i && data_req_i) begin
                    gnt_src = (starve_q == SLIM) ? SRC_INST : SRC_DATA;
                end else begin
                    gnt_src = data_req_i ? SRC_DATA : SRC_INST;
                end
                m_req_raw = ~fifo_full & (inst_req_i | data_req_i);
                if (m_req_raw && !m_addr_ok_i) begin
                    state_d = (gnt_src == SRC_DATA) ? ST_HOLD_D : ST_HOLD_I;
                end
            end
            ST_HOLD_I: begin
                gnt_src   = SRC_INST;
                m_req_raw = ~fifo_full & inst_req_i;
                if (m_addr_ok_i || !inst_req_i) state_d = ST_IDLE;
            end
            ST_HOLD_D: begin
                gnt_src   = SRC_DATA;
                m_req_raw = ~fifo_full & data_req_i;
                if (m_addr_ok_i || !data_req_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_req_o = m_req_raw & ~areset_i;
    assign m_r     = (gnt_src == SRC_DATA) ? data_r : inst_r;
    assign m_wr_o    = m_r.wr;
    assign m_size_o  = m_r.size;
    assign m_addr_o  = m_r.addr;
    assign m_wstrb_o = m_r.wstrb;
    assign m_wdata_o = m_r.wdata;

    assign accept         = m_req_o & m_addr_ok_i;
    assign inst_addr_ok_o = accept & (gnt_src == SRC_INST);
    assign data_addr_ok_o = accept & (gnt_src == SRC_DATA);

    // Responses with nothing outstanding are flagged, never routed
    assign pop            = m_data_ok_i & ~fifo_empty & ~areset_i;
    assign inst_data_ok_o = pop & (fifo_head == SRC_INST);
    assign data_data_ok_o = pop & (fifo_head == SRC_DATA);
    assign inst_rdata_o   = inst_data_ok_o ? m_rdata_i : 32'h0;
    assign data_rdata_o   = data_data_ok_o ? m_rdata_i : 32'h0;
    assign err_d          = err_q | (m_data_ok_i & fifo_empty);
    assign err_orphan_o   = err_q;

    always_comb begin
        starve_d = starve_q;
        if (!inst_req_i || inst_addr_ok_o) begin
            starve_d = '0;
        end else if (data_addr_ok_o && starve_q != SLIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    arb_order_fifo #(
        .DEPTH (OUTST)
    ) u_order_fifo (
        .clk_i   (aclk_i),
        .rst_i   (areset_i),
        .push_i  (accept),
        .pop_i   (pop),
        .tag_i   (gnt_src),
        .head_o  (fifo_head),
        .count_o (outst_cnt_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, table-driven bench for sram_req_arbiter (OUTST=4, STARVE_LIMIT=3).
module tb_sram_req_arbiter;

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic        aclk, areset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [2:0]  outst_cnt;
    logic        err_orphan;

    int n_assert = 0;
    int n_fail   = 0;

    sram_req_arbiter #(.OUTST(4), .STARVE_LIMIT(3)) dut (
        .aclk_i(aclk), .areset_i(areset),
        .inst_req_i(inst_req), .inst_wr_i(inst_wr), .inst_size_i(inst_size),
        .inst_addr_i(inst_addr), .inst_wstrb_i(inst_wstrb), .inst_wdata_i(inst_wdata),
        .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
        .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size),
        .data_addr_i(data_addr), .data_wstrb_i(data_wstrb), .data_wdata_i(data_wdata),
        .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok), .data_rdata_o(data_rdata),
        .m_req_o(m_req), .m_wr_o(m_wr), .m_size_o(m_size), .m_addr_o(m_addr),
        .m_wstrb_o(m_wstrb), .m_wdata_o(m_wdata), .m_addr_ok_i(m_addr_ok),
        .m_data_ok_i(m_data_ok), .m_rdata_i(m_rdata),
        .outst_cnt_o(outst_cnt), .err_orphan_o(err_orphan)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rd;
        logic        e_mreq, e_src, e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_ird, e_drd;
        logic [2:0]  e_cnt;
        logic        e_orph;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic ir, dr, aok, dok, input logic [31:0] rd,
                                input logic e_mreq, e_src, e_iaok, e_daok, e_idok, e_ddok,
                                input logic [31:0] e_ird, e_drd, input logic [2:0] e_cnt,
                                input logic e_orph);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_mreq = e_mreq; v.e_src = e_src; v.e_iaok = e_iaok; v.e_daok = e_daok;
        v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_ird = e_ird; v.e_drd = e_drd;
        v.e_cnt = e_cnt; v.e_orph = e_orph;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait to the falling edge
    task automatic cyc(input logic ir, dr, aok, dok, input logic [31:0] rd);
        @(posedge aclk);
        #1;
        inst_req = ir; data_req = dr; m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
        @(negedge aclk);
    endtask

    task automatic chk_src(input string nm, input logic src);
        chk({nm, "_addr"}, m_addr, src ? DA : IA);
        chk({nm, "_wr"},   32'(m_wr), 32'(src));
    endtask

    initial begin
        areset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = IA;
        inst_wstrb = 4'hF; inst_wdata = 32'hAAAA_0000;
        data_req = 0; data_wr = 1; data_size = 2'd2; data_addr = DA;
        data_wstrb = 4'h3; data_wdata = 32'hBBBB_0000;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;

        //            ir dr ok dk rdata         mreq src iaok daok idok ddok ird           drd           cnt orph
        vecs[0]  = mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  3'd1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h0280_0000, 0, 0, 0, 0, 1, 0, 32'h0280_0000, 32'h0,  3'd1, 0);
        vecs[3]  = mk(1, 1, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,         1, 1, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[6]  = mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[7]  = mk(0, 0, 0, 1, 32'h55,        0, 0, 0, 0, 0, 1, 32'h0,         32'h55, 3'd1, 0);
        vecs[8]  = mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 32'h0,         32'h0,  3'd1, 0);
        vecs[10] = mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         32'h0,  3'd2, 0);
        vecs[11] = mk(0, 0, 0, 1, 32'h11,        0, 0, 0, 0, 1, 0, 32'h11,        32'h0,  3'd3, 0);
        vecs[12] = mk(0, 0, 0, 1, 32'h22,        0, 0, 0, 0, 0, 1, 32'h0,         32'h22, 3'd2, 0);
        vecs[13] = mk(0, 0, 0, 1, 32'h33,        0, 0, 0, 0, 1, 0, 32'h33,        32'h0,  3'd1, 0);
        vecs[14] = mk(0, 0, 0, 1, 32'h44,        0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 0);
        vecs[15] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 1);
        vecs[16] = mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 32'h0,         32'h0,  3'd0, 1);
        vecs[17] = mk(0, 1, 1, 1, 32'h66,        1, 1, 0, 1, 1, 0, 32'h66,        32'h0,  3'd1, 1);
        vecs[18] = mk(0, 0, 0, 1, 32'h77,        0, 0, 0, 0, 0, 1, 32'h0,         32'h77, 3'd1, 1);
        vecs[19] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  3'd0, 1);

        // Reset values while areset is held
        #12;
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_cnt", 32'(outst_cnt), 32'h0);
        chk("rst_orphan", 32'(err_orphan), 32'h0);
        @(posedge aclk);
        #1 areset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rd);
            chk($sformatf("v%0d_m_req", i), 32'(m_req), 32'(vecs[i].e_mreq));
            if (vecs[i].e_mreq) chk_src($sformatf("v%0d", i), vecs[i].e_src);
            chk($sformatf("v%0d_iaok", i), 32'(inst_addr_ok), 32'(vecs[i].e_iaok));
            chk($sformatf("v%0d_daok", i), 32'(data_addr_ok), 32'(vecs[i].e_daok));
            chk($sformatf("v%0d_idok", i), 32'(inst_data_ok), 32'(vecs[i].e_idok));
            chk($sformatf("v%0d_ddok", i), 32'(data_data_ok), 32'(vecs[i].e_ddok));
            chk($sformatf("v%0d_irdata", i), inst_rdata, vecs[i].e_ird);
            chk($sformatf("v%0d_drdata", i), data_rdata, vecs[i].e_drd);
            chk($sformatf("v%0d_cnt", i), 32'(outst_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_orphan", i), 32'(err_orphan), 32'(vecs[i].e_orph));
        end

        // Starvation: both request every cycle, bridge accepts and answers every cycle
        for (int k = 0; k < 8; k++) begin
            cyc(1, 1, 1, (k > 0), 32'h100 + 32'(k));
            chk($sformatf("starve%0d_m_req", k), 32'(m_req), 32'h1);
            chk_src($sformatf("starve%0d", k), (k % 4 == 3) ? 1'b0 : 1'b1);
            chk($sformatf("starve%0d_iaok", k), 32'(inst_addr_ok), (k % 4 == 3) ? 32'h1 : 32'h0);
        end
        cyc(0, 0, 0, 1, 32'h0);
        chk("starve_drain_idok", 32'(inst_data_ok), 32'h1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("starve_cnt", 32'(outst_cnt), 32'h0);

        // Full: four accepts, then no grant even with a same-cycle pop
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, 0, 32'h0);
            chk($sformatf("fill%0d_iaok", k), 32'(inst_addr_ok), 32'h1);
        end
        cyc(1, 0, 1, 0, 32'h0);
        chk("full_cnt", 32'(outst_cnt), 32'h4);
        chk("full_m_req", 32'(m_req), 32'h0);
        chk("full_iaok", 32'(inst_addr_ok), 32'h0);
        cyc(1, 0, 1, 1, 32'hCAFE);
        chk("full_pop_m_req", 32'(m_req), 32'h0);
        chk("full_pop_idok", 32'(inst_data_ok), 32'h1);
        chk("full_pop_irdata", inst_rdata, 32'hCAFE);
        cyc(1, 0, 1, 0, 32'h0);
        chk("refill_cnt", 32'(outst_cnt), 32'h3);
        chk("refill_m_req", 32'(m_req), 32'h1);
        chk("refill_iaok", 32'(inst_addr_ok), 32'h1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("drain_cnt", 32'(outst_cnt), 32'h0);

        // Reset mid-stream with three outstanding
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 32'h0);
        @(posedge aclk);
        #1;
        inst_req = 1; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hDEAD;
        #1 areset = 1'b1;
        #1;
        chk("midrst_m_req", 32'(m_req), 32'h0);
        chk("midrst_iaok", 32'(inst_addr_ok), 32'h0);
        chk("midrst_idok", 32'(inst_data_ok), 32'h0);
        chk("midrst_irdata", inst_rdata, 32'h0);
        chk("midrst_cnt", 32'(outst_cnt), 32'h0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        inst_req = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        @(negedge aclk);
        chk("postrst_cnt", 32'(outst_cnt), 32'h0);
        chk("postrst_orphan", 32'(err_orphan), 32'h0);
        chk("postrst_idok", 32'(inst_data_ok), 32'h0);
        cyc(1, 0, 1, 0, 32'h0);
        chk("postrst_m_req", 32'(m_req), 32'h1);
        chk_src("postrst", 1'b0);
        chk("postrst_iaok", 32'(inst_addr_ok), 32'h1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("postrst_cnt1", 32'(outst_cnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
